mac_stream_feeder: RTL and testbench
====================================

// Module: mac_stream_feeder
// PURPOSE
//  Upstream writer for the mac block's signal and coefficient FIFOs. It first loads N_TAPS
//  coefficients, then streams samples. Both inputs use valid/ready handshakes.
//  It paces writes against the MAC FIFO full/empty flags and drains cleanly on stop.
//  Sits between the sample source/config bus and mac (signal_fifo/coeff_fifo inputs).
// PARAMETERS
//  DATA_WIDTH  32  width of samples and coefficients
//  ADDR_LINES  4   MAC FIFO address width; must match mac instance
//  N_TAPS      16  coefficients per load; 1..2**ADDR_LINES
// PORTS
//  clk_i           in   1           single clock, all logic on rising edge
//  rstn_i          in   1           reset, synchronous, active-low
//  cfg_start_i     in   1           pulse: begin coefficient load (honoured in IDLE only)
//  stop_i          in   1           pulse: end sample streaming, drain (honoured in STREAM only)
//  coeff_valid_i   in   1           upstream coefficient beat valid
//  coeff_data_i    in   DATA_WIDTH  upstream coefficient
//  coeff_ready_o   out  1           coefficient beat accepted when valid&ready
//  sample_valid_i  in   1           upstream sample beat valid
//  sample_data_i   in   DATA_WIDTH  upstream sample
//  sample_ready_o  out  1           sample beat accepted when valid&ready
//  full_mul_i      in   1           mac signal FIFO full
//  empty_mul_i     in   1           mac signal FIFO empty
//  full_adder_i    in   1           mac coefficient FIFO full
//  signal_o        out  DATA_WIDTH  to mac signal_fifo
//  signal_wr_o     out  1           1-cycle strobe: signal_o valid this cycle
//  coeff_o         out  DATA_WIDTH  to mac coeff_fifo
//  coeff_wr_o      out  1           1-cycle strobe: coeff_o valid this cycle
//  tap_cnt_o       out  ADDR_LINES  coefficients accepted in current load
//  coeff_loaded_o  out  1           N_TAPS coefficients written since last cfg_start_i
//  busy_o          out  1           state != IDLE
// BEHAVIOUR
//  Reset (rstn_i=0 at edge): state=IDLE; all outputs 0; in-flight beat discarded, even mid-load.
//  FSM:
//  - IDLE -> LOAD_COEFF on cfg_start_i; tap_cnt=0, coeff_loaded=0.
//  - LOAD_COEFF -> STREAM when beat N_TAPS-1 is accepted; coeff_loaded_o=1 next cycle.
//  - STREAM -> DRAIN on stop_i; a sample beat accepted in the same cycle is still written.
//  - DRAIN -> IDLE when empty_mul_i=1 and no signal_wr_o pending; coeff_loaded_o stays 1.
//  Readies, combinational from registered state and flags:
//  - coeff_ready_o = (state==LOAD_COEFF) & !full_adder_i & !coeff_wr_o.
//  - sample_ready_o = (state==STREAM) & !full_mul_i & !signal_wr_o.
//  - The !wr_o term limits each path to 1 beat per 2 cycles, so a full flag is never stale.
//  Latency: beat accepted at edge N -> data_o registered and wr strobe high for cycle N+1.
//  data_o holds the last written value between strobes.
//  tap_cnt wraps to 0 when the load completes (the N_TAPS=2**ADDR_LINES case is covered by the same wrap).
//  Flags: full asserting while a strobe is high does not cancel that write.
//  Ignored inputs (no error): cfg_start_i outside IDLE; stop_i outside STREAM.
//  Also ignored: valid with ready low; the beat is held upstream.
//  Never: signal_wr_o in LOAD_COEFF; coeff_wr_o in STREAM or DRAIN.
// STRUCTURE
//  Shared package: FSM state localparams (IDLE/LOAD_COEFF/STREAM/DRAIN, 2-bit).
//  The package also holds the common DATA_WIDTH/ADDR_LINES defaults used with mac.
//  One sub-module: feeder_beat_reg (valid/ready accept -> registered data + 1-cycle wr strobe).
//  It is instanced twice, for the coefficient and sample paths; the FSM and tap counter stay in top.
// TESTING
//  1. Reset: hold rstn_i=0 3 cycles -> all outputs 0, busy_o=0.
//  2. Coefficient load: cfg_start_i, 16 beats 0x1..0x10 always valid
//     -> coeff_wr_o 16 times on alternate cycles, in order.
//     coeff_loaded_o=1 after beat 16; tap_cnt_o back to 0.
//  3. Backpressure: full_adder_i=1 for 5 cycles mid-load -> coeff_ready_o=0, no coeff_wr_o.
//     Load resumes with no lost or duplicated value.
//  4. Stream and drain: samples 0xA0..0xA7; stop_i with 0xA7 accepted that cycle
//     -> 0xA7 is written; FSM stays in DRAIN until empty_mul_i=1, then IDLE.
//  5. Mid-load reset: rstn_i=0 after 7 coefficients -> IDLE, tap_cnt_o=0.
//     No strobe for the beat accepted in the reset cycle.
//  6. Illegal controls: stop_i in LOAD_COEFF and cfg_start_i in STREAM -> state and counters unchanged.

Source files
------------

// File: rtl/mac_stream_feeder_pkg.sv
// Shared definitions for the mac stream feeder and its mac instance.
// Holds the feeder FSM state encoding and the default datapath geometry.
// No logic; imported by the feeder top and its sub-module.
package mac_stream_feeder_pkg;

  // Defaults shared with the mac instance (FIFO address width must match it)
  localparam int DEF_DATA_WIDTH = 32;
  localparam int DEF_ADDR_LINES = 4;

  typedef enum logic [1:0] {
    ST_IDLE       = 2'd0,
    ST_LOAD_COEFF = 2'd1,
    ST_STREAM     = 2'd2,
    ST_DRAIN      = 2'd3
  } state_t;

endpackage

// File: rtl/feeder_beat_reg.sv
// One valid/ready beat stage: accepted beat -> registered data + 1-cycle write strobe.
// Latency: accept at edge N, o_wr high and o_dat valid for cycle N+1.
// Backpressure: ready drops on i_full or while a strobe is out (max 1 beat per 2 cycles).
module feeder_beat_reg import mac_stream_feeder_pkg::*; #(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
  input  logic                  clk_i,
  input  logic                  rstn_i,
  input  logic                  i_en,
  input  logic                  i_full,
  input  logic                  i_vld,
  input  logic [DATA_WIDTH-1:0] i_dat,
  output logic                  o_rdy,
  output logic [DATA_WIDTH-1:0] o_dat,
  output logic                  o_wr
);

  logic                  r_wr;
  logic [DATA_WIDTH-1:0] r_dat;
  logic                  w_acc;

  // Blocking on our own strobe means the FIFO full flag seen here already
  // reflects the previous write, so it can never be stale.
  assign o_rdy = i_en & ~i_full & ~r_wr;
  assign w_acc = i_vld & o_rdy;
  assign o_wr  = r_wr;
  assign o_dat = r_dat;

  // Capture the accepted beat; data holds between strobes, reset drops any in-flight beat
  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      r_wr  <= 1'b0;
      r_dat <= '0;
    end else begin
      r_wr <= w_acc;
      if (w_acc) r_dat <= i_dat;
    end
  end

endmodule

// File: rtl/mac_stream_feeder.sv
// Feeds the mac coefficient FIFO (N_TAPS beats per load) then its signal FIFO until stop.
// Latency: one cycle from upstream accept to the registered write strobe/data.
// Backpressure: readies gated by state, mac full flags and the outstanding strobe.
module mac_stream_feeder import mac_stream_feeder_pkg::*; #(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ADDR_LINES = DEF_ADDR_LINES,
  parameter int N_TAPS     = 16
) (
  input  logic                  clk_i,
  input  logic                  rstn_i,
  input  logic                  cfg_start_i,
  input  logic                  stop_i,
  input  logic                  coeff_valid_i,
  input  logic [DATA_WIDTH-1:0] coeff_data_i,
  output logic                  coeff_ready_o,
  input  logic                  sample_valid_i,
  input  logic [DATA_WIDTH-1:0] sample_data_i,
  output logic                  sample_ready_o,
  input  logic                  full_mul_i,
  input  logic                  empty_mul_i,
  input  logic                  full_adder_i,
  output logic [DATA_WIDTH-1:0] signal_o,
  output logic                  signal_wr_o,
  output logic [DATA_WIDTH-1:0] coeff_o,
  output logic                  coeff_wr_o,
  output logic [ADDR_LINES-1:0] tap_cnt_o,
  output logic                  coeff_loaded_o,
  output logic                  busy_o
);

  // Final tap index; with N_TAPS = 2**ADDR_LINES the counter wraps to 0 naturally as well
  localparam logic [ADDR_LINES-1:0] LAST_TAP = ADDR_LINES'(N_TAPS - 1);

  state_t                r_state;
  logic [ADDR_LINES-1:0] r_tap_cnt;
  logic                  r_coeff_loaded;
  logic                  w_coeff_acc;

  feeder_beat_reg #(.DATA_WIDTH(DATA_WIDTH)) u_coeff_beat (
    .clk_i  (clk_i),
    .rstn_i (rstn_i),
    .i_en   (r_state == ST_LOAD_COEFF),
    .i_full (full_adder_i),
    .i_vld  (coeff_valid_i),
    .i_dat  (coeff_data_i),
    .o_rdy  (coeff_ready_o),
    .o_dat  (coeff_o),
    .o_wr   (coeff_wr_o)
  );

  feeder_beat_reg #(.DATA_WIDTH(DATA_WIDTH)) u_sample_beat (
    .clk_i  (clk_i),
    .rstn_i (rstn_i),
    .i_en   (r_state == ST_STREAM),
    .i_full (full_mul_i),
    .i_vld  (sample_valid_i),
    .i_dat  (sample_data_i),
    .o_rdy  (sample_ready_o),
    .o_dat  (signal_o),
    .o_wr   (signal_wr_o)
  );

  assign w_coeff_acc    = coeff_valid_i & coeff_ready_o;
  assign tap_cnt_o      = r_tap_cnt;
  assign coeff_loaded_o = r_coeff_loaded;
  assign busy_o         = (r_state != ST_IDLE);

  // Load/stream/drain sequencing with the per-load tap counter
  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      r_state        <= ST_IDLE;
      r_tap_cnt      <= '0;
      r_coeff_loaded <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (cfg_start_i) begin
            r_state        <= ST_LOAD_COEFF;
            r_tap_cnt      <= '0;
            r_coeff_loaded <= 1'b0;
          end
        end
        ST_LOAD_COEFF: begin
          if (w_coeff_acc) begin
            if (r_tap_cnt == LAST_TAP) begin
              r_tap_cnt      <= '0;
              r_coeff_loaded <= 1'b1;
              r_state        <= ST_STREAM;
            end else begin
              r_tap_cnt <= r_tap_cnt + 1'b1;
            end
          end
        end
        ST_STREAM: begin
          // A sample accepted alongside stop still gets its strobe next cycle
          if (stop_i) r_state <= ST_DRAIN;
        end
        ST_DRAIN: begin
          // Wait for the last strobe to land and the mac to consume everything
          if (empty_mul_i && !signal_wr_o) r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mac_stream_feeder.sv
// Self-checking bench for mac_stream_feeder: directed + randomized load/stream/drain.
// Reference model tracks the phase and expected write order via queues.
// Outputs sampled at negedge (readies) and 1 time unit after posedge (registered outputs).
module tb_mac_stream_feeder;

  localparam int DW = 32;
  localparam int AL = 4;
  localparam int NT = 16;

  logic          clk_i = 1'b0;
  logic          rstn_i;
  logic          cfg_start_i, stop_i;
  logic          coeff_valid_i, sample_valid_i;
  logic [DW-1:0] coeff_data_i, sample_data_i;
  logic          coeff_ready_o, sample_ready_o;
  logic          full_mul_i, empty_mul_i, full_adder_i;
  logic [DW-1:0] signal_o, coeff_o;
  logic          signal_wr_o, coeff_wr_o;
  logic [AL-1:0] tap_cnt_o;
  logic          coeff_loaded_o, busy_o;

  always #5 clk_i = ~clk_i;

  mac_stream_feeder #(.DATA_WIDTH(DW), .ADDR_LINES(AL), .N_TAPS(NT)) dut (
    .clk_i(clk_i), .rstn_i(rstn_i), .cfg_start_i(cfg_start_i), .stop_i(stop_i),
    .coeff_valid_i(coeff_valid_i), .coeff_data_i(coeff_data_i), .coeff_ready_o(coeff_ready_o),
    .sample_valid_i(sample_valid_i), .sample_data_i(sample_data_i), .sample_ready_o(sample_ready_o),
    .full_mul_i(full_mul_i), .empty_mul_i(empty_mul_i), .full_adder_i(full_adder_i),
    .signal_o(signal_o), .signal_wr_o(signal_wr_o), .coeff_o(coeff_o), .coeff_wr_o(coeff_wr_o),
    .tap_cnt_o(tap_cnt_o), .coeff_loaded_o(coeff_loaded_o), .busy_o(busy_o)
  );

  int checks = 0;
  int errors = 0;

  // Model: phase 0 idle, 1 loading, 2 streaming, 3 draining
  int            m_ph = 0;
  int            m_tap = 0;
  logic          m_loaded = 1'b0, m_cwr = 1'b0, m_swr = 1'b0;
  logic [DW-1:0] m_cdat = '0, m_sdat = '0;
  logic [DW-1:0] cq[$];
  logic [DW-1:0] sq[$];
  logic          c_acc, s_acc;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic exp_crdy();
    return (m_ph == 1) && !full_adder_i && !m_cwr;
  endfunction

  function automatic logic exp_srdy();
    return (m_ph == 2) && !full_mul_i && !m_swr;
  endfunction

  // One clock: check readies, advance the model across the edge, check registered outputs
  task automatic tick();
    @(negedge clk_i);
    chk("coeff_ready", coeff_ready_o, exp_crdy());
    chk("sample_ready", sample_ready_o, exp_srdy());
    c_acc = coeff_valid_i && exp_crdy();
    s_acc = sample_valid_i && exp_srdy();
    @(posedge clk_i);
    #1;
    if (!rstn_i) begin
      m_ph = 0; m_tap = 0; m_loaded = 0; m_cwr = 0; m_swr = 0; m_cdat = '0; m_sdat = '0;
    end else begin
      case (m_ph)
        0: if (cfg_start_i) begin m_ph = 1; m_tap = 0; m_loaded = 0; end
        1: if (c_acc) begin
             m_tap = m_tap + 1;
             if (m_tap == NT) begin m_tap = 0; m_loaded = 1; m_ph = 2; end
           end
        2: if (stop_i) m_ph = 3;
        default: if (empty_mul_i && !m_swr) m_ph = 0;
      endcase
      m_cwr = c_acc;
      m_swr = s_acc;
      if (m_cwr) begin
        if (cq.size() > 0) m_cdat = cq.pop_front();
        else chk("coeff_q_underflow", cq.size(), 1);
      end
      if (m_swr) begin
        if (sq.size() > 0) m_sdat = sq.pop_front();
        else chk("sample_q_underflow", sq.size(), 1);
      end
    end
    chk("coeff_wr", coeff_wr_o, m_cwr);
    chk("signal_wr", signal_wr_o, m_swr);
    chk("coeff_o", coeff_o, m_cdat);
    chk("signal_o", signal_o, m_sdat);
    chk("tap_cnt", tap_cnt_o, m_tap % (1 << AL));
    chk("coeff_loaded", coeff_loaded_o, m_loaded);
    chk("busy", busy_o, m_ph != 0);
  endtask

  initial begin
    int cptr, sptr, budget, stall, n;
    logic [DW-1:0] val;
    rstn_i = 0; cfg_start_i = 0; stop_i = 0; coeff_valid_i = 0; sample_valid_i = 0;
    coeff_data_i = '0; sample_data_i = '0; full_mul_i = 0; empty_mul_i = 0; full_adder_i = 0;
    @(posedge clk_i);
    #1;

    // Reset held for 3 cycles
    repeat (3) tick();
    rstn_i = 1;
    tick();

    // Directed load 0x1..0x10, always valid
    for (int i = 1; i <= NT; i++) cq.push_back(DW'(i));
    cfg_start_i = 1; tick(); cfg_start_i = 0;
    coeff_valid_i = 1; cptr = 0; budget = 200;
    while (cptr < NT && budget > 0) begin
      coeff_data_i = DW'(cptr + 1);
      tick();
      if (c_acc) cptr++;
      budget--;
    end
    chk("load1_count", cptr, NT);
    coeff_valid_i = 0;
    repeat (2) tick();
    chk("load1_q_empty", cq.size(), 0);

    // cfg_start in STREAM is ignored
    cfg_start_i = 1; tick(); cfg_start_i = 0; tick();

    // Stream 0xA0..0xA7 with stop on the cycle 0xA7 is accepted
    for (int i = 0; i < 8; i++) sq.push_back(DW'(32'hA0 + i));
    sample_valid_i = 1; sptr = 0; budget = 200;
    while (sptr < 8 && budget > 0) begin
      sample_data_i = DW'(32'hA0 + sptr);
      stop_i = (sptr == 7) && exp_srdy();
      tick();
      stop_i = 0;
      if (s_acc) sptr++;
      budget--;
    end
    chk("stream_count", sptr, 8);
    sample_valid_i = 0;
    repeat (5) tick();
    empty_mul_i = 1;
    repeat (3) tick();
    chk("stream_q_empty", sq.size(), 0);
    empty_mul_i = 0;

    // Random-valid load with a 5-cycle full stall mid-load and an ignored stop
    for (int i = 0; i < NT; i++) cq.push_back(DW'(32'h100 + i + 1));
    cfg_start_i = 1; tick(); cfg_start_i = 0;
    cptr = 0; stall = 0; budget = 400;
    while (cptr < NT && budget > 0) begin
      coeff_data_i = DW'(32'h100 + cptr + 1);
      coeff_valid_i = 1'($urandom_range(0, 1));
      full_adder_i = (cptr == 6 && stall < 5);
      if (full_adder_i) stall++;
      stop_i = (cptr == 3);
      tick();
      stop_i = 0;
      if (c_acc) cptr++;
      budget--;
    end
    chk("load2_count", cptr, NT);
    coeff_valid_i = 0; full_adder_i = 0;
    tick();
    chk("load2_q_empty", cq.size(), 0);

    // Randomized stream of 20 samples with random full backpressure, then drain
    n = 0; val = DW'($urandom); sq.push_back(val); budget = 800;
    while (n < 20 && budget > 0) begin
      sample_data_i = val;
      sample_valid_i = 1'($urandom_range(0, 1));
      full_mul_i = ($urandom_range(0, 3) == 0);
      tick();
      if (s_acc) begin
        n++;
        if (n < 20) begin val = DW'($urandom); sq.push_back(val); end
      end
      budget--;
    end
    chk("rand_stream_count", n, 20);
    sample_valid_i = 0; full_mul_i = 0;
    stop_i = 1; tick(); stop_i = 0;
    budget = 100;
    while (m_ph != 0 && budget > 0) begin
      empty_mul_i = 1'($urandom_range(0, 1));
      tick();
      budget--;
    end
    chk("drain_to_idle", m_ph, 0);
    chk("rand_q_empty", sq.size(), 0);
    empty_mul_i = 0;

    // Mid-load reset after 7 coefficients, with a beat accepted in the reset cycle
    for (int i = 0; i < NT; i++) cq.push_back(DW'(32'h200 + i));
    cfg_start_i = 1; tick(); cfg_start_i = 0;
    coeff_valid_i = 1; cptr = 0; budget = 100;
    while (cptr < 7 && budget > 0) begin
      coeff_data_i = DW'(32'h200 + cptr);
      tick();
      if (c_acc) cptr++;
      budget--;
    end
    chk("reset_load_count", cptr, 7);
    coeff_data_i = DW'(32'h200 + cptr);
    if (!exp_crdy()) tick();
    rstn_i = 0;
    tick();
    rstn_i = 1;
    coeff_valid_i = 0;
    cq.delete();
    repeat (2) tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
